// File: rtl/m_tile_seq_pkg.sv
// Shared types for the tile sequencer: the queued instruction word and the FSM states.
package Common;

  localparam int PKG_ROW_W  = 4;
  localparam int PKG_COLW_W = 4;
  localparam int PKG_COLA_W = 4;

  typedef struct packed {
    logic                  need_sync;
    logic [PKG_COLA_W-1:0] cola_end;
    logic [PKG_COLW_W-1:0] colw_end;
    logic [PKG_ROW_W-1:0]  row_end;
  } MTileInst;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, WAIT} MSeqState;

endpackage

// File: rtl/m_tile_seq_fifo.sv
// Synchronous instruction queue; one extra pointer bit separates full from empty.
module m_tile_seq_fifo #(
  parameter int W     = 13,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/m_tile_seq.sv
// Tile loop sequencer: walks row / column-W / column-A pointers per queued instruction,
// gating sync-point beats on credits from the downstream consumer.
//
// state | meaning
// IDLE  | no current instruction; waits for the queue to hold one
// LOAD  | pops queue head into the current instruction, clears pointers
// RUN   | issues beats; advances pointers on each handshake
// WAIT  | final beat issued; waits for array_done
module m_tile_seq
  import Common::*;
#(
  parameter int ROW_W      = PKG_ROW_W,
  parameter int COLW_W     = PKG_COLW_W,
  parameter int COLA_W     = PKG_COLA_W,
  parameter int FIFO_DEPTH = 4,
  parameter int CRED_W     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_valid,
  output logic              inst_ready,
  input  MTileInst          inst,
  input  logic              sync_credit,
  output logic              sync_release,
  output logic              issue_valid,
  input  logic              issue_ready,
  output logic [ROW_W-1:0]  row_ptr,
  output logic [COLW_W-1:0] colw_ptr,
  output logic [COLA_W-1:0] cola_ptr,
  output logic              tile_last,
  output logic              inst_last,
  input  logic              array_done,
  output logic              busy,
  output logic              cred_ovf
);

  MSeqState          state;
  MTileInst          cur;
  MTileInst          fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic [CRED_W-1:0] credits;
  logic              row_at_end;
  logic              colw_at_end;
  logic              cola_at_end;
  logic              sync_pt;
  logic              final_beat;
  logic              hs;

  assign inst_ready = ~fifo_full;
  assign push       = inst_valid & ~fifo_full;
  assign pop        = (state == LOAD);

  m_tile_seq_fifo #(
    .W    ($bits(MTileInst)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .din  (inst),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign row_at_end  = (row_ptr == cur.row_end);
  assign colw_at_end = (colw_ptr == cur.colw_end);
  assign cola_at_end = (cola_ptr == cur.cola_end);
  assign sync_pt     = cur.need_sync & row_at_end & colw_at_end;
  assign final_beat  = row_at_end & colw_at_end & cola_at_end;

  // A sync-point beat is held back entirely until a credit is available.
  assign issue_valid  = (state == RUN) & ~(sync_pt & (credits == '0));
  assign hs           = issue_valid & issue_ready;
  assign tile_last    = issue_valid & row_at_end;
  assign inst_last    = issue_valid & final_beat;
  assign sync_release = hs & sync_pt;
  assign busy         = (state != IDLE) | ~fifo_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cur      <= '0;
      row_ptr  <= '0;
      colw_ptr <= '0;
      cola_ptr <= '0;
    end else begin
      case (state)
        IDLE: if (!fifo_empty) state <= LOAD;
        LOAD: begin
          cur      <= fifo_dout;
          row_ptr  <= '0;
          colw_ptr <= '0;
          cola_ptr <= '0;
          state    <= RUN;
        end
        RUN: if (hs) begin
          if (final_beat) begin
            state <= WAIT;
          end else if (row_at_end) begin
            row_ptr <= '0;
            if (colw_at_end) begin
              colw_ptr <= '0;
              cola_ptr <= cola_ptr + 1'b1;
            end else begin
              colw_ptr <= colw_ptr + 1'b1;
            end
          end else begin
            row_ptr <= row_ptr + 1'b1;
          end
        end
        WAIT: if (array_done) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // A credit arriving in the same cycle as a consume cancels out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits  <= '0;
      cred_ovf <= 1'b0;
    end else if (sync_credit && !sync_release) begin
      if (credits == '1) cred_ovf <= 1'b1;
      else               credits  <= credits + 1'b1;
    end else if (!sync_credit && sync_release) begin
      credits <= credits - 1'b1;
    end
  end

endmodule

// File: tb/tb_m_tile_seq.sv
// Scoreboard bench for m_tile_seq: instructions expand into expected beats from loop rules.
module tb_m_tile_seq;
  import Common::*;

  localparam int CRED_MAX = 7;

  logic       clk = 1'b0;
  logic       rst;
  logic       inst_valid;
  logic       inst_ready;
  MTileInst   inst;
  logic       sync_credit;
  logic       sync_release;
  logic       issue_valid;
  logic       issue_ready = 1'b0;
  logic [3:0] row_ptr;
  logic [3:0] colw_ptr;
  logic [3:0] cola_ptr;
  logic       tile_last;
  logic       inst_last;
  logic       array_done = 1'b0;
  logic       busy;
  logic       cred_ovf;

  typedef struct packed {
    logic [3:0] row;
    logic [3:0] colw;
    logic [3:0] cola;
    logic       tl;
    logic       il;
    logic       sync;
  } beat_t;

  beat_t exp_q[$];
  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int hs_count = 0;
  int last_hs_cyc = 0;
  int model_cred = 0;
  bit model_ovf = 0;
  int done_req_cnt = 0;
  int done_ack_cnt = 0;
  int dly = 0;
  int rdy_mode = 0;
  bit cred_rand = 0;
  bit cred_manual = 0;
  bit cred_rnd_bit = 0;
  bit noise = 0;

  assign sync_credit = cred_rand ? cred_rnd_bit : cred_manual;

  m_tile_seq dut (
    .clk         (clk),
    .rst         (rst),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .sync_credit (sync_credit),
    .sync_release(sync_release),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .row_ptr     (row_ptr),
    .colw_ptr    (colw_ptr),
    .cola_ptr    (cola_ptr),
    .tile_last   (tile_last),
    .inst_last   (inst_last),
    .array_done  (array_done),
    .busy        (busy),
    .cred_ovf    (cred_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endfunction

  function automatic MTileInst mk(bit ns, int ca, int cw, int re);
    MTileInst m;
    m.need_sync = ns;
    m.cola_end  = ca[3:0];
    m.colw_end  = cw[3:0];
    m.row_end   = re[3:0];
    return m;
  endfunction

  // Reference: nested loops, column-A outermost, row innermost.
  function automatic void push_model(MTileInst x);
    for (int a = 0; a <= int'(x.cola_end); a++)
      for (int w = 0; w <= int'(x.colw_end); w++)
        for (int r = 0; r <= int'(x.row_end); r++) begin
          beat_t b;
          b.row  = r[3:0];
          b.colw = w[3:0];
          b.cola = a[3:0];
          b.tl   = (r == int'(x.row_end));
          b.il   = b.tl && (w == int'(x.colw_end)) && (a == int'(x.cola_end));
          b.sync = x.need_sync && b.tl && (w == int'(x.colw_end));
          exp_q.push_back(b);
        end
  endfunction

  // Background drivers: issue_ready pattern, random credits, array_done responder.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       issue_ready = 1'b1;
      1:       issue_ready = ~issue_ready;
      2:       issue_ready = 1'($urandom_range(0, 1));
      default: issue_ready = 1'b0;
    endcase
    cred_rnd_bit = ($urandom_range(0, 3) == 0);
    array_done = 1'b0;
    if (done_ack_cnt != done_req_cnt) begin
      if (dly == 0) begin
        array_done = 1'b1;
        done_ack_cnt++;
        dly = $urandom_range(0, 2);
      end else begin
        dly--;
      end
    end else if (noise && $urandom_range(0, 15) == 0) begin
      array_done = 1'b1;
    end
  end

  // Monitor: compare every presented beat to the scoreboard head.
  always @(negedge clk) begin
    beat_t e;
    bit cons;
    cons = 0;
    if (rst) begin
      exp_q.delete();
      model_cred = 0;
      model_ovf = 0;
      done_req_cnt = done_ack_cnt;
    end else begin
      chk("cred_ovf", cred_ovf, model_ovf);
      if (exp_q.size() > 0 && exp_q[0].sync && model_cred == 0)
        chk("sync_stall", issue_valid, 0);
      if (issue_valid) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_beat: got row %0d colw %0d cola %0d required no beat", row_ptr, colw_ptr, cola_ptr);
        end else begin
          e = exp_q[0];
          chk("beat", {row_ptr, colw_ptr, cola_ptr, tile_last, inst_last}, {e.row, e.colw, e.cola, e.tl, e.il});
          if (issue_ready) begin
            chk("sync_release", sync_release, e.sync);
            hs_count++;
            cons = e.sync;
            if (e.il) begin
              last_hs_cyc = cyc;
              done_req_cnt++;
            end
            void'(exp_q.pop_front());
          end else begin
            chk("release_no_hs", sync_release, 0);
          end
        end
      end else begin
        chk("idle_flags", {tile_last, inst_last, sync_release}, 0);
      end
      if (sync_credit && !cons) begin
        if (model_cred == CRED_MAX) model_ovf = 1;
        else model_cred++;
      end else if (!sync_credit && cons) begin
        model_cred--;
      end
    end
  end

  task automatic push_inst(MTileInst x);
    int g = 0;
    bit acc = 0;
    @(posedge clk); #1;
    inst_valid = 1'b1;
    inst = x;
    while (!acc && g < 300) begin
      @(negedge clk);
      acc = inst_ready;
      @(posedge clk); #1;
      g++;
    end
    inst_valid = 1'b0;
    if (acc) push_model(x);
    else chk("push_timeout", 0, 1);
  endtask

  task automatic wait_hs(int target, int budget);
    int g = 0;
    while (hs_count < target && g < budget) begin
      @(negedge clk);
      g++;
    end
    chk("hs_reached", hs_count >= target, 1);
  endtask

  task automatic wait_valid(int budget);
    int g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (!issue_valid && g < budget);
    chk("valid_seen", issue_valid, 1);
  endtask

  task automatic pulse_credit();
    @(posedge clk); #1;
    cred_manual = 1'b1;
    @(posedge clk); #1;
    cred_manual = 1'b0;
  endtask

  task automatic drain(int budget);
    int g = 0;
    while ((exp_q.size() != 0 || done_ack_cnt != done_req_cnt) && g < budget) begin
      @(negedge clk);
      g++;
    end
    chk("drain_pending", exp_q.size() + (done_req_cnt - done_ack_cnt), 0);
    repeat (3) @(negedge clk);
    chk("busy_idle", busy, 0);
  endtask

  task automatic timed_push(MTileInst x, output int n_cyc);
    @(posedge clk); #1;
    n_cyc = cyc;
    inst_valid = 1'b1;
    inst = x;
    @(negedge clk);
    chk("timed_push_ready", inst_ready, 1);
    @(posedge clk); #1;
    inst_valid = 1'b0;
    push_model(x);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int first;
    int base;
    int g;
    bit r;
    rst = 1'b1;
    inst_valid = 1'b0;
    inst = '0;
    repeat (2) @(negedge clk);
    chk("rst_inst_ready", inst_ready, 1);
    chk("rst_outs", {issue_valid, sync_release, tile_last, inst_last, busy, cred_ovf}, 0);
    chk("rst_ptrs", {row_ptr, colw_ptr, cola_ptr}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // single instruction, latency and loop order
    base = hs_count;
    timed_push(mk(0, 0, 1, 3), n);
    first = -1;
    g = 0;
    while (first < 0 && g < 10) begin
      @(negedge clk);
      if (issue_valid) first = cyc;
      g++;
    end
    chk("latency", first - n, 3);
    drain(200);
    chk("single_beats", hs_count - base, 8);

    // backpressure
    rdy_mode = 1;
    base = hs_count;
    timed_push(mk(0, 0, 1, 3), n);
    drain(200);
    chk("bp_beats", hs_count - base, 8);
    chk("bp_last_cycle", (last_hs_cyc - n) >= 17, 1);
    rdy_mode = 0;

    // sync points without credits
    base = hs_count;
    push_inst(mk(1, 1, 0, 1));
    wait_hs(base + 1, 50);
    repeat (5) @(negedge clk);
    chk("sync1_valid", issue_valid, 0);
    chk("sync1_cnt", hs_count - base, 1);
    pulse_credit();
    wait_hs(base + 2, 20);
    wait_hs(base + 3, 20);
    repeat (5) @(negedge clk);
    chk("sync2_valid", issue_valid, 0);
    chk("sync2_cnt", hs_count - base, 3);
    pulse_credit();
    drain(100);
    chk("sync_beats", hs_count - base, 4);

    // credit saturation and coincident credit/consume
    repeat (8) pulse_credit();
    @(negedge clk);
    chk("cred_ovf_set", cred_ovf, 1);
    base = hs_count;
    push_inst(mk(1, 8, 0, 0));
    wait_valid(20);
    pulse_credit();
    wait_hs(base + 8, 60);
    repeat (5) @(negedge clk);
    chk("cred_stall_cnt", hs_count - base, 8);
    chk("cred_stall_valid", issue_valid, 0);
    pulse_credit();
    drain(100);
    chk("cred_beats", hs_count - base, 9);

    // queue fill while the array stalls
    rdy_mode = 3;
    base = hs_count;
    push_inst(mk(0, 0, 0, 3));
    wait_valid(20);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      inst_valid = 1'b1;
      inst = mk(0, 0, 0, i);
      @(negedge clk);
      r = inst_ready;
      chk("q_ready", r, (i < 4));
      if (r) push_model(mk(0, 0, 0, i));
    end
    @(posedge clk); #1;
    inst_valid = 1'b0;
    rdy_mode = 0;
    drain(300);
    chk("q_beats", hs_count - base, 14);

    // randomized traffic
    rdy_mode = 2;
    cred_rand = 1;
    noise = 1;
    for (int t = 0; t < 20; t++) begin
      push_inst(mk(1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 3)));
      repeat ($urandom_range(0, 4)) @(posedge clk);
    end
    drain(5000);
    cred_rand = 0;
    noise = 0;
    rdy_mode = 0;

    // reset in the middle of RUN with work queued
    push_inst(mk(0, 3, 3, 3));
    push_inst(mk(0, 0, 0, 1));
    push_inst(mk(0, 1, 0, 2));
    wait_valid(20);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_inst_ready", inst_ready, 1);
    chk("mid_rst_outs", {issue_valid, sync_release, tile_last, inst_last, busy, cred_ovf}, 0);
    chk("mid_rst_ptrs", {row_ptr, colw_ptr, cola_ptr}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_valid", issue_valid, 0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
